ahmes_control: RTL and testbench

- Multicycle control unit that sequences the Ahmes 8-bit datapath: PC, MAR, MDR, RI, AC, flag register, ALU and single-port memory.
- Drives the PC's `load`/`inc` strobes and every other register-enable and memory strobe.
- Instantiated beside PC inside the CPU top.
- Implements fetch, decode and execute for the full Ahmes instruction set, with a ready handshake on memory.

---
 rtl/ahmes_pkg.sv | 64 ++++++
 rtl/ahmes_control_if.sv | 31 +++
 rtl/ahmes_branch_eval.sv | 53 +++++
 rtl/ahmes_control.sv | 111 +++++++++++
 tb/tb_ahmes_control.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahmes_pkg.sv
// Shared types and constants for the Ahmes control unit: FSM states, ALU
// operation codes, opcode groups and jump sub-codes.
package ahmes_pkg;

    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_DEC,
        S_A0, S_A1, S_A2, S_X0, S_W0,
        S_ALU, S_J0, S_J1, S_J2, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_PASS, ALU_ADD, ALU_OR, ALU_AND, ALU_NOT,
        ALU_SUB, ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL
    } alu_op_t;

    // Opcode groups, taken from the upper nibble of RI.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_STA   = 4'h1;
    localparam logic [3:0] OP_LDA   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_NOT   = 4'h6;
    localparam logic [3:0] OP_SUB   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JNV   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JCB   = 4'hB;
    localparam logic [3:0] OP_SHIFT = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

    // Conditional-jump sub-codes in RI[3:2].
    localparam logic [1:0] JSUB_N  = 2'd0;
    localparam logic [1:0] JSUB_P  = 2'd1;
    localparam logic [1:0] JSUB_V  = 2'd2;
    localparam logic [1:0] JSUB_NV = 2'd3;
    localparam logic [1:0] JSUB_C  = 2'd0;
    localparam logic [1:0] JSUB_NC = 2'd1;
    localparam logic [1:0] JSUB_B  = 2'd2;
    localparam logic [1:0] JSUB_NB = 2'd3;

    function automatic alu_op_t alu_op_of(input logic [7:0] ri);
        alu_op_t op;
        op = ALU_PASS;
        case (ri[7:4])
            OP_ADD:   op = ALU_ADD;
            OP_OR:    op = ALU_OR;
            OP_AND:   op = ALU_AND;
            OP_NOT:   op = ALU_NOT;
            OP_SUB:   op = ALU_SUB;
            OP_SHIFT: begin
                case (ri[1:0])
                    2'd0:    op = ALU_SHR;
                    2'd1:    op = ALU_SHL;
                    2'd2:    op = ALU_ROR;
                    default: op = ALU_ROL;
                endcase
            end
            default:  op = ALU_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ahmes_control_if.sv
// Signal bundle between the Ahmes control unit (master) and the datapath and
// memory it sequences (slave).
interface ahmes_control_if;
    import ahmes_pkg::*;

    // Memory handshake: mem_read/mem_write is a request that stays high until
    // the cycle in which mem_ready is 1; that cycle completes the transfer.
    // mem_ready with no request pending has no effect.
    logic [7:0] ri_in;
    logic       flag_n, flag_z, flag_v, flag_c, flag_b;
    logic       mem_ready;
    logic       pc_inc, pc_load;
    logic       mar_load, mar_sel;
    logic       mem_read, mem_write;
    logic       mdr_load, ri_load, ac_load, flags_load;
    alu_op_t    alu_op;
    logic       halted;

    modport master (
        input  ri_in, flag_n, flag_z, flag_v, flag_c, flag_b, mem_ready,
        output pc_inc, pc_load, mar_load, mar_sel, mem_read, mem_write,
        output mdr_load, ri_load, ac_load, flags_load, alu_op, halted
    );

    modport slave (
        output ri_in, flag_n, flag_z, flag_v, flag_c, flag_b, mem_ready,
        input  pc_inc, pc_load, mar_load, mar_sel, mem_read, mem_write,
        input  mdr_load, ri_load, ac_load, flags_load, alu_op, halted
    );

endinterface

// File: rtl/ahmes_branch_eval.sv
// Classifies the opcode in RI as a jump and evaluates its condition against
// the registered flags.
module ahmes_branch_eval
    import ahmes_pkg::*;
(
    input  logic [7:0] ri_in,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_b,
    output logic       is_jump,
    output logic       taken
);

    always_comb begin
        is_jump = 1'b0;
        taken   = 1'b0;
        case (ri_in[7:4])
            OP_JMP: begin
                is_jump = 1'b1;
                taken   = 1'b1;
            end
            OP_JNV: begin
                is_jump = 1'b1;
                case (ri_in[3:2])
                    JSUB_N:  taken = flag_n;
                    JSUB_P:  taken = !flag_n && !flag_z;
                    JSUB_V:  taken = flag_v;
                    default: taken = !flag_v;
                endcase
            end
            OP_JZ: begin
                is_jump = 1'b1;
                taken   = ri_in[2] ? !flag_z : flag_z;
            end
            OP_JCB: begin
                is_jump = 1'b1;
                case (ri_in[3:2])
                    JSUB_C:  taken = flag_c;
                    JSUB_NC: taken = !flag_c;
                    JSUB_B:  taken = flag_b;
                    default: taken = !flag_b;
                endcase
            end
            default: begin
                is_jump = 1'b0;
                taken   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahmes_control.sv
// Multicycle fetch/decode/execute sequencer for the Ahmes datapath. Strobes are
// decoded from the registered state, RI and mem_ready.
module ahmes_control
    import ahmes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    ahmes_control_if.master   bus,
    output state_t            state_dbg
);

    state_t state;
    logic   is_jump;
    logic   taken;

    ahmes_branch_eval u_branch (
        .ri_in   (bus.ri_in),
        .flag_n  (bus.flag_n),
        .flag_z  (bus.flag_z),
        .flag_v  (bus.flag_v),
        .flag_c  (bus.flag_c),
        .flag_b  (bus.flag_b),
        .is_jump (is_jump),
        .taken   (taken)
    );

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_F0;
        end else begin
            case (state)
                S_F0:  state <= S_F1;
                S_F1:  if (bus.mem_ready) state <= S_F2;
                S_F2:  state <= S_DEC;
                S_DEC: begin
                    case (bus.ri_in[7:4])
                        OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB:
                            state <= S_A0;
                        OP_NOT, OP_SHIFT:
                            state <= S_ALU;
                        OP_HLT:
                            state <= S_HALT;
                        default:
                            state <= (is_jump && taken) ? S_J0 : S_F0;
                    endcase
                end
                S_A0:  state <= S_A1;
                S_A1:  if (bus.mem_ready) state <= S_A2;
                S_A2:  state <= (bus.ri_in[7:4] == OP_STA) ? S_W0 : S_X0;
                S_X0:  if (bus.mem_ready) state <= S_ALU;
                S_W0:  if (bus.mem_ready) state <= S_F0;
                S_ALU: state <= S_F0;
                S_J0:  state <= S_J1;
                S_J1:  if (bus.mem_ready) state <= S_J2;
                S_J2:  state <= S_F0;
                S_HALT: state <= S_HALT;
                default: state <= S_F0;
            endcase
        end
    end

    // The reset term keeps every strobe quiet in the reset cycle itself,
    // whatever state the register still holds.
    always_comb begin
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.mar_load   = 1'b0;
        bus.mar_sel    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mdr_load   = 1'b0;
        bus.ri_load    = 1'b0;
        bus.ac_load    = 1'b0;
        bus.flags_load = 1'b0;
        bus.alu_op     = ALU_PASS;
        bus.halted     = 1'b0;
        if (!reset) begin
            case (state)
                S_F0, S_A0, S_J0: bus.mar_load = 1'b1;
                S_F1, S_A1: begin
                    bus.mem_read = 1'b1;
                    bus.mdr_load = bus.mem_ready;
                    bus.pc_inc   = bus.mem_ready;
                end
                S_F2: bus.ri_load = 1'b1;
                S_DEC: bus.pc_inc = is_jump && !taken
                                    && (bus.ri_in[7:4] != OP_HLT);
                S_A2: begin
                    bus.mar_load = 1'b1;
                    bus.mar_sel  = 1'b1;
                end
                S_X0, S_J1: begin
                    bus.mem_read = 1'b1;
                    bus.mdr_load = bus.mem_ready;
                end
                S_W0: bus.mem_write = 1'b1;
                S_ALU: begin
                    bus.ac_load    = 1'b1;
                    bus.flags_load = 1'b1;
                    bus.alu_op     = alu_op_of(bus.ri_in);
                end
                S_J2: bus.pc_load = 1'b1;
                S_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahmes_control.sv
// Scoreboard bench for ahmes_control: an instruction-level model queues the
// expected strobe words, a negedge monitor pops and compares them.
module tb_ahmes_control;
    import ahmes_pkg::*;

    localparam int W = 14;
    localparam logic [W-1:0] B_PCINC = 14'h2000;
    localparam logic [W-1:0] B_PCLD  = 14'h1000;
    localparam logic [W-1:0] B_MAR   = 14'h0800;
    localparam logic [W-1:0] B_SEL   = 14'h0400;
    localparam logic [W-1:0] B_RD    = 14'h0200;
    localparam logic [W-1:0] B_WR    = 14'h0100;
    localparam logic [W-1:0] B_MDR   = 14'h0080;
    localparam logic [W-1:0] B_RI    = 14'h0040;
    localparam logic [W-1:0] B_AC    = 14'h0020;
    localparam logic [W-1:0] B_FL    = 14'h0010;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    state_t state_dbg;
    ahmes_control_if bus ();

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int wr_cycles = 0;
    logic mon_en = 1'b0;

    ahmes_control dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic [W-1:0] strobe_word();
        return {bus.pc_inc, bus.pc_load, bus.mar_load, bus.mar_sel,
                bus.mem_read, bus.mem_write, bus.mdr_load, bus.ri_load,
                bus.ac_load, bus.flags_load, 4'(bus.alu_op)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        reset = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("reset_quiet", {18'd0, bus.halted, strobe_word()}, 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Expected completed-strobe words for one instruction, from the
    // instruction's documented step list; returns its length in cycles.
    task automatic model_push(input logic [7:0] op, input logic [4:0] fl, output int ncyc);
        logic n, z, v, c, b, tk;
        logic [3:0] hi, aop;
        n = fl[4]; z = fl[3]; v = fl[2]; c = fl[1]; b = fl[0];
        hi = op[7:4];
        exp_q.push_back(B_MAR);
        exp_q.push_back(B_RD | B_MDR | B_PCINC);
        exp_q.push_back(B_RI);
        ncyc = 4;
        if (hi inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7}) begin
            exp_q.push_back(B_MAR);
            exp_q.push_back(B_RD | B_MDR | B_PCINC);
            exp_q.push_back(B_MAR | B_SEL);
            if (hi == 4'h1) begin
                exp_q.push_back(B_WR);
                ncyc = 8;
            end else begin
                case (hi)
                    4'h2: aop = 4'd0;
                    4'h3: aop = 4'd1;
                    4'h4: aop = 4'd2;
                    4'h5: aop = 4'd3;
                    default: aop = 4'd5;
                endcase
                exp_q.push_back(B_RD | B_MDR);
                exp_q.push_back(B_AC | B_FL | {10'd0, aop});
                ncyc = 9;
            end
        end else if (hi == 4'h6 || hi == 4'hE) begin
            aop = (hi == 4'h6) ? 4'd4 : 4'd6 + {2'd0, op[1:0]};
            exp_q.push_back(B_AC | B_FL | {10'd0, aop});
            ncyc = 5;
        end else if (hi >= 4'h8 && hi <= 4'hB) begin
            tk = 1'b1;
            if (hi == 4'h9) tk = (op[3:2] == 0) ? n : (op[3:2] == 1) ? (!n && !z) :
                                 (op[3:2] == 2) ? v : !v;
            if (hi == 4'hA) tk = op[2] ? !z : z;
            if (hi == 4'hB) tk = (op[3:2] == 0) ? c : (op[3:2] == 1) ? !c :
                                 (op[3:2] == 2) ? b : !b;
            if (tk) begin
                exp_q.push_back(B_MAR);
                exp_q.push_back(B_RD | B_MDR);
                exp_q.push_back(B_PCLD);
                ncyc = 7;
            end else begin
                exp_q.push_back(B_PCINC);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Entered at posedge+1 of an F0 cycle. rnd: random mem_ready; otherwise
    // mem_ready is low for cycles [st, st+sl) of the instruction.
    task automatic run_instr(input logic [7:0] op, input logic [4:0] fl, input bit rnd,
                             input int st, input int sl);
        int ncyc, cyc;
        bus.ri_in = op;
        {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c, bus.flag_b} = fl;
        model_push(op, fl, ncyc);
        cyc = 0;
        while (1) begin
            bus.mem_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st && cyc < st + sl);
            @(posedge clk); #1;
            cyc++;
            if (state_dbg == S_F0) break;
            if (cyc >= 200) begin
                checks++;
                failures++;
                $display("FAIL timeout op=0x%0h: no return to fetch after %0d cycles", op, cyc);
                return;
            end
        end
        if (!rnd) check($sformatf("cycles_op%0h", op), cyc, ncyc + sl);
        check($sformatf("drained_op%0h", op), exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] w, e;
        if (mon_en && !reset) begin
            w = strobe_word();
            if (bus.mem_write) wr_cycles++;
            if (bus.mem_read && bus.mem_write) begin
                checks++; failures++;
                $display("FAIL rd_wr_both: got 0x%0h", w);
            end
            if (bus.pc_inc && bus.pc_load) begin
                checks++; failures++;
                $display("FAIL pcinc_pcload: got 0x%0h", w);
            end
            if ((bus.mem_read || bus.mem_write) && !bus.mem_ready) begin
                check("hold", w, bus.mem_read ? B_RD : B_WR);
            end else if (w != '0) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_strobe: got 0x%0h expected none", w);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe", w, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] op;
        logic [4:0] fl;
        bus.ri_in = 8'h00;
        {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c, bus.flag_b} = 5'd0;
        bus.mem_ready = 1'b1;
        #1;
        do_reset(2);

        repeat (3) run_instr(8'h00, 5'd0, 0, 0, 0);
        run_instr(8'h20, 5'd0, 0, 0, 0);

        wr_cycles = 0;
        run_instr(8'h10, 5'd0, 0, 7, 3);
        check("sta_write_held", wr_cycles, 4);

        run_instr(8'hA0, 5'b01000, 0, 0, 0);
        run_instr(8'hA0, 5'b00000, 0, 0, 0);
        run_instr(8'h80, 5'd0, 0, 0, 0);
        run_instr(8'h60, 5'd0, 0, 0, 0);
        run_instr(8'hE3, 5'd0, 0, 0, 0);
        run_instr(8'h70, 5'd0, 0, 0, 0);
        run_instr(8'h30, 5'd0, 1, 0, 0);

        // HLT: three fetch strobes, then silence until reset.
        bus.ri_in = 8'hF0;
        bus.mem_ready = 1'b1;
        exp_q.push_back(B_MAR);
        exp_q.push_back(B_RD | B_MDR | B_PCINC);
        exp_q.push_back(B_RI);
        repeat (4) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_quiet", {bus.halted, strobe_word()}, {1'b1, 14'd0});
            @(posedge clk); #1;
        end
        check("halt_drained", exp_q.size(), 0);
        do_reset(1);
        run_instr(8'h00, 5'd0, 0, 0, 0);

        // Reset while X0 waits on memory: no ALU write-back may follow.
        bus.ri_in = 8'h20;
        exp_q.push_back(B_MAR);
        exp_q.push_back(B_RD | B_MDR | B_PCINC);
        exp_q.push_back(B_RI);
        exp_q.push_back(B_MAR);
        exp_q.push_back(B_RD | B_MDR | B_PCINC);
        exp_q.push_back(B_MAR | B_SEL);
        for (int c = 0; c < 8; c++) begin
            bus.mem_ready = (c < 7);
            @(posedge clk); #1;
        end
        check("x0_prefix_drained", exp_q.size(), 0);
        bus.mem_ready = 1'b0;
        do_reset(1);
        run_instr(8'h00, 5'd0, 0, 0, 0);

        // Random opcodes and flags, ready always high: exact cycle counts.
        for (int i = 0; i < 60; i++) begin
            op = 8'($urandom_range(0, 255));
            if (op[7:4] == 4'hF) op[7:4] = 4'h0;
            fl = 5'($urandom_range(0, 31));
            run_instr(op, fl, 0, 0, 0);
        end
        // Random opcodes and flags with random memory stalls.
        for (int i = 0; i < 120; i++) begin
            op = 8'($urandom_range(0, 255));
            if (op[7:4] == 4'hF) op[7:4] = 4'h0;
            fl = 5'($urandom_range(0, 31));
            run_instr(op, fl, 1, 0, 0);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
